// File: rtl/cfg_bitstream_router.sv
`default_nettype none
// ============================================================================
// Module   : cfg_bitstream_router
// Purpose  : Parses framed configuration bytes (IDX, LEN_LO, LEN_HI, payload)
//            and serialises each payload LSB-first to the selected CLB port.
// Revision : 1.0 - initial release
// ============================================================================
module cfg_bitstream_router #(
    parameter int NUM_CLBS = 4,
    parameter int LEN_W    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_tvalid,
    output logic                in_tready,
    input  logic [7:0]          in_tdata,
    input  logic                in_tlast,
    output logic [NUM_CLBS-1:0] clb_cfg,
    output logic [NUM_CLBS-1:0] clb_tvalid,
    input  logic [NUM_CLBS-1:0] clb_tready,
    output logic                clb_tdata,
    output logic                clb_tlast,
    output logic                busy,
    output logic                err
);

    typedef enum logic [2:0] {
        S_IDX     = 3'd0,
        S_LEN_LO  = 3'd1,
        S_LEN_HI  = 3'd2,
        S_CFG     = 3'd3,
        S_LOAD    = 3'd4,
        S_SHIFT   = 3'd5,
        S_DISCARD = 3'd6
    } state_t;

    localparam logic [8:0] C_NUM_CLBS = 9'(NUM_CLBS);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [7:0]         r_idx;
    logic [7:0]         r_len_lo;
    logic [7:0]         r_shreg;
    logic [LEN_W-1:0]   r_remaining;
    logic [2:0]         r_bitcnt;
    logic               r_err;
    logic               r_abort;
    logic               r_started;
    logic [NUM_CLBS-1:0] w_sel;
    logic [15:0]        w_len;
    logic               w_in_fire;
    logic               w_out_fire;
    logic               w_err_set;
    logic               w_last_bit;
    logic               w_early_last;

    for (genvar gi = 0; gi < NUM_CLBS; gi++) begin : g_sel
        assign w_sel[gi] = (r_idx == 8'(gi));
    end

    // in_tready stays low until the first clock after reset release
    assign in_tready = r_started &&
                       (r_state == S_IDX || r_state == S_LEN_LO || r_state == S_LEN_HI ||
                        r_state == S_LOAD || r_state == S_DISCARD);

    assign w_in_fire    = in_tvalid & in_tready;
    assign w_out_fire   = (r_state == S_SHIFT) && ((clb_tready & w_sel) != '0);
    assign w_len        = {in_tdata, r_len_lo};
    assign w_last_bit   = (r_remaining == LEN_W'(1));
    // A payload byte carrying in_tlast that does not hold the final bit
    assign w_early_last = in_tlast && (r_remaining > LEN_W'(8));

    assign clb_cfg    = (r_state == S_CFG)   ? w_sel : '0;
    assign clb_tvalid = (r_state == S_SHIFT) ? w_sel : '0;
    assign clb_tdata  = (r_state == S_SHIFT) && r_shreg[0];
    assign clb_tlast  = (r_state == S_SHIFT) && w_last_bit;
    assign busy       = (r_state != S_IDX);
    assign err        = r_err;

    always_comb begin
        w_state_nxt = r_state;
        w_err_set   = 1'b0;
        case (r_state)
            S_IDX: begin
                if (w_in_fire) begin
                    if (in_tlast) begin
                        w_err_set   = 1'b1;
                        w_state_nxt = S_IDX;
                    end else if ({1'b0, in_tdata} >= C_NUM_CLBS) begin
                        w_err_set   = 1'b1;
                        w_state_nxt = S_DISCARD;
                    end else begin
                        w_state_nxt = S_LEN_LO;
                    end
                end
            end
            S_LEN_LO: begin
                if (w_in_fire) begin
                    if (in_tlast) begin
                        w_err_set   = 1'b1;
                        w_state_nxt = S_IDX;
                    end else begin
                        w_state_nxt = S_LEN_HI;
                    end
                end
            end
            S_LEN_HI: begin
                if (w_in_fire) begin
                    if (in_tlast) begin
                        w_err_set   = 1'b1;
                        w_state_nxt = S_IDX;
                    end else if (w_len == 16'd0) begin
                        w_err_set   = 1'b1;
                        w_state_nxt = S_DISCARD;
                    end else begin
                        w_state_nxt = S_CFG;
                    end
                end
            end
            S_CFG: w_state_nxt = S_LOAD;
            S_LOAD: begin
                if (w_in_fire) begin
                    w_err_set   = w_early_last;
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (w_out_fire) begin
                    if (w_last_bit) begin
                        w_state_nxt = S_IDX;
                    end else if (r_bitcnt == 3'd7) begin
                        // An aborted frame still drains the byte already loaded
                        w_state_nxt = r_abort ? S_IDX : S_LOAD;
                    end
                end
            end
            S_DISCARD: begin
                if (w_in_fire && in_tlast) begin
                    w_state_nxt = S_IDX;
                end
            end
            default: w_state_nxt = S_IDX;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDX;
            r_idx       <= '0;
            r_len_lo    <= '0;
            r_shreg     <= '0;
            r_remaining <= '0;
            r_bitcnt    <= '0;
            r_err       <= 1'b0;
            r_abort     <= 1'b0;
            r_started   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_started <= 1'b1;
            if (w_err_set) begin
                r_err <= 1'b1;
            end
            case (r_state)
                S_IDX: begin
                    if (w_in_fire) r_idx <= in_tdata;
                end
                S_LEN_LO: begin
                    if (w_in_fire) r_len_lo <= in_tdata;
                end
                S_LEN_HI: begin
                    if (w_in_fire) r_remaining <= LEN_W'(w_len);
                end
                S_LOAD: begin
                    if (w_in_fire) begin
                        r_shreg  <= in_tdata;
                        r_bitcnt <= '0;
                        r_abort  <= w_early_last;
                    end
                end
                S_SHIFT: begin
                    if (w_out_fire) begin
                        r_shreg     <= r_shreg >> 1;
                        r_remaining <= r_remaining - LEN_W'(1);
                        r_bitcnt    <= r_bitcnt + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cfg_bitstream_router.sv
`default_nettype none
// ============================================================================
// Module   : tb_cfg_bitstream_router
// Purpose  : Scoreboard bench for cfg_bitstream_router with directed frames.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cfg_bitstream_router;

    localparam int N = 4;

    typedef logic [N+1:0] exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_tvalid;
    logic         in_tready;
    logic [7:0]   in_tdata;
    logic         in_tlast;
    logic [N-1:0] clb_cfg;
    logic [N-1:0] clb_tvalid;
    logic [N-1:0] clb_tready;
    logic         clb_tdata;
    logic         clb_tlast;
    logic         busy;
    logic         err;

    exp_t         bit_q[$];
    logic [N-1:0] cfg_q[$];
    int           n_checks = 0;
    int           n_pass   = 0;
    int           hs_count = 0;
    logic         tog_mode = 1'b0;

    cfg_bitstream_router #(.NUM_CLBS(N), .LEN_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_tvalid  (in_tvalid),
        .in_tready  (in_tready),
        .in_tdata   (in_tdata),
        .in_tlast   (in_tlast),
        .clb_cfg    (clb_cfg),
        .clb_tvalid (clb_tvalid),
        .clb_tready (clb_tready),
        .clb_tdata  (clb_tdata),
        .clb_tlast  (clb_tlast),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Queue one expected bit per character of s; tlast on the final one if last
    task automatic exp_bits(input int clb, input string s, input logic last);
        logic [N-1:0] oh;
        oh      = '0;
        oh[clb] = 1'b1;
        for (int i = 0; i < s.len(); i++) begin
            bit_q.push_back({oh, (s[i] == 8'h31), (last && (i == s.len() - 1))});
        end
    endtask

    task automatic send(input logic [7:0] b, input logic last);
        int t;
        t = 0;
        @(negedge clk);
        in_tdata  = b;
        in_tlast  = last;
        in_tvalid = 1'b1;
        while (!in_tready && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 1000) begin
            check("send_timeout", {31'd0, in_tready}, 32'd1);
            in_tvalid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_tvalid = 1'b0;
        in_tlast  = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] idx, input logic [7:0] lo, input logic [7:0] hi);
        send(idx, 1'b0);
        send(lo, 1'b0);
        send(hi, 1'b0);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((bit_q.size() != 0 || cfg_q.size() != 0) && t < 2000) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (t >= 2000) check("idle_timeout", bit_q.size() + cfg_q.size(), 32'd0);
        repeat (2) @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bit_q.delete();
        cfg_q.delete();
    endtask

    // Per-CLB ready: all ones, or toggling every cycle for the stall test
    initial begin
        clb_tready = '1;
        forever begin
            @(posedge clk);
            #1;
            if (tog_mode) clb_tready = ~clb_tready;
            else          clb_tready = '1;
        end
    end

    // Monitor: pops the scoreboard on every cfg pulse and bit handshake
    initial begin
        exp_t         prev;
        exp_t         e;
        logic [N-1:0] ec;
        logic         stalled;
        stalled = 1'b0;
        prev    = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stalled = 1'b0;
            end else begin
                if (clb_cfg != '0) begin
                    check("cfg_tready_low", {31'd0, in_tready}, 32'd0);
                    if (cfg_q.size() == 0) begin
                        check("cfg_unexpected", {28'd0, clb_cfg}, 32'd0);
                    end else begin
                        ec = cfg_q.pop_front();
                        check("cfg_pulse", {28'd0, clb_cfg}, {28'd0, ec});
                    end
                end
                if (clb_tvalid != '0) begin
                    check("shift_tready_low", {31'd0, in_tready}, 32'd0);
                    if (stalled) check("stall_stable", {clb_tvalid, clb_tdata, clb_tlast}, prev);
                    if ((clb_tvalid & clb_tready) != '0) begin
                        hs_count++;
                        stalled = 1'b0;
                        if (bit_q.size() == 0) begin
                            check("bit_unexpected", {26'd0, clb_tvalid, clb_tdata, clb_tlast}, 32'd0);
                        end else begin
                            e = bit_q.pop_front();
                            check("bit", {26'd0, clb_tvalid, clb_tdata, clb_tlast}, {26'd0, e});
                        end
                    end else begin
                        stalled = 1'b1;
                        prev    = {clb_tvalid, clb_tdata, clb_tlast};
                    end
                end else begin
                    stalled = 1'b0;
                end
            end
        end
    end

    initial begin
        int base;
        int t;
        in_tvalid = 1'b0;
        in_tdata  = '0;
        in_tlast  = 1'b0;
        rst_n     = 1'b0;

        #12;
        check("rst_in_tready", {31'd0, in_tready}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_outs", {22'd0, clb_cfg, clb_tvalid, clb_tdata, clb_tlast}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("in_tready_after_rst", {31'd0, in_tready}, 32'd1);

        // Basic frame: L=10, A5 then 03
        cfg_q.push_back(4'b0010);
        exp_bits(1, "1010010111", 1'b1);
        send_frame(8'h01, 8'h0A, 8'h00);
        send(8'hA5, 1'b0);
        send(8'h03, 1'b1);
        wait_idle();
        check("basic_err", {31'd0, err}, 32'd0);
        check("basic_busy", {31'd0, busy}, 32'd0);

        // Same frame with ready toggling
        tog_mode = 1'b1;
        cfg_q.push_back(4'b0010);
        exp_bits(1, "1010010111", 1'b1);
        send_frame(8'h01, 8'h0A, 8'h00);
        send(8'hA5, 1'b0);
        send(8'h03, 1'b1);
        wait_idle();
        tog_mode = 1'b0;
        check("bp_err", {31'd0, err}, 32'd0);

        // Back-to-back frames to CLB0 (L=3) and CLB3 (L=8)
        cfg_q.push_back(4'b0001);
        exp_bits(0, "011", 1'b1);
        cfg_q.push_back(4'b1000);
        exp_bits(3, "11111111", 1'b1);
        send_frame(8'h00, 8'h03, 8'h00);
        send(8'h06, 1'b0);
        send_frame(8'h03, 8'h08, 8'h00);
        send(8'hFF, 1'b1);
        wait_idle();
        check("b2b_err", {31'd0, err}, 32'd0);

        // Out-of-range index, then a good frame with err still set
        send(8'h07, 1'b0);
        send(8'hAA, 1'b0);
        send(8'h01, 1'b0);
        send(8'h02, 1'b1);
        wait_idle();
        check("badidx_err", {31'd0, err}, 32'd1);
        check("badidx_busy", {31'd0, busy}, 32'd0);
        cfg_q.push_back(4'b0100);
        exp_bits(2, "00111", 1'b1);
        send_frame(8'h02, 8'h05, 8'h00);
        send(8'h1C, 1'b1);
        wait_idle();
        check("after_bad_err", {31'd0, err}, 32'd1);

        // L=0 goes to discard until in_tlast
        do_reset();
        check("rst2_err", {31'd0, err}, 32'd0);
        send_frame(8'h02, 8'h00, 8'h00);
        wait_idle();
        check("len0_err", {31'd0, err}, 32'd1);
        check("len0_discarding", {31'd0, busy}, 32'd1);
        send(8'h55, 1'b1);
        wait_idle();
        check("len0_idle", {31'd0, busy}, 32'd0);

        // Early in_tlast on the first of two payload bytes
        do_reset();
        cfg_q.push_back(4'b0100);
        exp_bits(2, "00111100", 1'b0);
        send_frame(8'h02, 8'h10, 8'h00);
        send(8'h3C, 1'b1);
        wait_idle();
        check("early_err", {31'd0, err}, 32'd1);
        check("early_idle", {31'd0, busy}, 32'd0);

        // Asynchronous reset after three bits of a frame
        do_reset();
        base = hs_count;
        cfg_q.push_back(4'b0010);
        exp_bits(1, "1010010111", 1'b1);
        send_frame(8'h01, 8'h0A, 8'h00);
        send(8'hA5, 1'b0);
        t = 0;
        while (hs_count < base + 3 && t < 200) begin
            @(posedge clk);
            #2;
            t++;
        end
        if (t >= 200) check("midrst_wait", hs_count - base, 32'd3);
        rst_n = 1'b0;
        #1;
        check("midrst_outs", {22'd0, clb_cfg, clb_tvalid, clb_tdata, clb_tlast}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_in_tready", {31'd0, in_tready}, 32'd0);
        bit_q.delete();
        cfg_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cfg_q.push_back(4'b0010);
        exp_bits(1, "1010010111", 1'b1);
        send_frame(8'h01, 8'h0A, 8'h00);
        send(8'hA5, 1'b0);
        send(8'h03, 1'b1);
        wait_idle();
        check("post_rst_err", {31'd0, err}, 32'd0);
        check("post_rst_busy", {31'd0, busy}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
